mc_control: RTL and testbench

- Multi-cycle controller that sequences the shared MIPS datapath (single ALU, single data-memory port, GRF, PC/IR registers) through FETCH/DECODE/EXE/MEM/WB.
- Supported instructions: addu, subu, ori, lw, sw, beq, lui, j, jal, jr.
- Drives per-state write enables and mux selects, and handles a req/ack handshake with data memory, including a timeout.
- Keeps a retired-instruction counter.

---
 rtl/mc_control_pkg.sv | 61 ++++++
 rtl/mc_decode.sv | 32 +++
 rtl/mc_control.sv | 189 ++++++++++++++++++
 tb/tb_mc_control.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// rtl/mc_control_pkg.sv - state encodings, instruction codes and control-field codes for mc_control
package mc_defs;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RA = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;
    localparam logic [1:0] WD_LUI = 2'b11;

    localparam logic [1:0] B_RT   = 2'b00;
    localparam logic [1:0] B_SIMM = 2'b01;
    localparam logic [1:0] B_ZIMM = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    // One-hot instruction class; nop covers every unrecognised op/fuc pair.
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic j;
        logic jal;
        logic jr;
        logic nop;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational op/fuc to one-hot instruction class
module mc_decode
    import mc_defs::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] fuc_i,
    output iclass_t    cls_o
);

    always_comb begin
        cls_o = '0;
        case (op_i)
            OP_RTYPE: begin
                case (fuc_i)
                    FN_ADDU: cls_o.addu = 1'b1;
                    FN_SUBU: cls_o.subu = 1'b1;
                    FN_JR:   cls_o.jr   = 1'b1;
                    default: cls_o.nop  = 1'b1;
                endcase
            end
            OP_ORI:  cls_o.ori = 1'b1;
            OP_LW:   cls_o.lw  = 1'b1;
            OP_SW:   cls_o.sw  = 1'b1;
            OP_BEQ:  cls_o.beq = 1'b1;
            OP_LUI:  cls_o.lui = 1'b1;
            OP_J:    cls_o.j   = 1'b1;
            OP_JAL:  cls_o.jal = 1'b1;
            default: cls_o.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS control FSM with memory handshake, timeout and retire counter
module mc_control
    import mc_defs::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       fuc,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCctrl,
    output logic             RegWrite,
    output logic [1:0]       Regdst,
    output logic [1:0]       WDctrl,
    output logic [1:0]       ALUctrl,
    output logic [2:0]       ALUOp,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             instr_done,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       err_q;
    logic [CNT_W-1:0] retired_q;
    logic       err_set;
    iclass_t    cls;
    logic [2:0] alu_op;
    logic [1:0] alu_b;

    mc_decode u_decode (
        .op_i  (op),
        .fuc_i (fuc),
        .cls_o (cls)
    );

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = B_RT;
        if (cls.subu || cls.beq) begin
            alu_op = ALU_SUB;
        end else if (cls.ori) begin
            alu_op = ALU_OR;
            alu_b  = B_ZIMM;
        end else if (cls.lw || cls.sw) begin
            alu_b  = B_SIMM;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        err_set    = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCctrl     = PC_PLUS4;
        RegWrite   = 1'b0;
        Regdst     = RD_RT;
        WDctrl     = WD_ALU;
        ALUctrl    = B_RT;
        ALUOp      = ALU_ADD;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                PCctrl  = PC_PLUS4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cls.j || cls.jal) begin
                    PCWrite    = 1'b1;
                    PCctrl     = PC_JUMP;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                    if (cls.jal) begin
                        RegWrite = 1'b1;
                        Regdst   = RD_RA;
                        WDctrl   = WD_PC;
                    end
                end else if (cls.jr) begin
                    PCWrite    = 1'b1;
                    PCctrl     = PC_REG;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (cls.nop) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                ALUOp   = alu_op;
                ALUctrl = alu_b;
                if (cls.beq) begin
                    PCWrite    = zero;
                    PCctrl     = PC_BRANCH;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (cls.lw || cls.sw) begin
                    wait_d  = 8'd0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                ALUOp    = alu_op;
                ALUctrl  = alu_b;
                mem_req  = 1'b1;
                MemWrite = cls.sw;
                wait_d   = wait_q + 8'd1;
                // An ack in the last permitted cycle still completes the access.
                if (mem_ack) begin
                    if (cls.sw) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    err_set = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
                if (cls.addu || cls.subu) begin
                    Regdst = RD_RD;
                    WDctrl = WD_ALU;
                end else if (cls.lui) begin
                    WDctrl = WD_LUI;
                end else if (cls.lw) begin
                    WDctrl = WD_MEM;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Reset must silence every side effect in the very cycle it is seen.
        if (reset) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= 8'd0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (instr_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign mem_err = err_q;
    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed self-checking bench for mc_control
module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, fuc;
    logic        zero, mem_ack;
    logic        IRWrite, PCWrite, RegWrite, mem_req, MemWrite, instr_done, mem_err;
    logic [1:0]  PCctrl, Regdst, WDctrl, ALUctrl;
    logic [2:0]  ALUOp, state;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;
    int nreq   = 0;
    int nregw  = 0;
    int ndone  = 0;

    mc_control #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .fuc        (fuc),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCctrl     (PCctrl),
        .RegWrite   (RegWrite),
        .Regdst     (Regdst),
        .WDctrl     (WDctrl),
        .ALUctrl    (ALUctrl),
        .ALUOp      (ALUOp),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .instr_done (instr_done),
        .mem_err    (mem_err),
        .retired    (retired),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, let outputs settle, tally pulses.
    task automatic tick(input logic [5:0] o, input logic [5:0] f, input logic z,
                        input logic a, input logic r);
        @(negedge clk);
        op = o; fuc = f; zero = z; mem_ack = a; reset = r;
        #1;
        if (mem_req)    nreq++;
        if (RegWrite)   nregw++;
        if (instr_done) ndone++;
    endtask

    initial begin
        reset = 1'b1; op = '0; fuc = '0; zero = 1'b0; mem_ack = 1'b0;
        tick(6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        tick(6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_irwrite", 32'(IRWrite), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_memerr", 32'(mem_err), 32'd0);

        // addu
        tick(6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0);
        chk("addu_fetch_state", 32'(state), 32'd0);
        chk("addu_fetch_ir_pc", {IRWrite, PCWrite, PCctrl}, 32'b1100);
        tick(6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0);
        chk("addu_dec_state", 32'(state), 32'd1);
        chk("addu_dec_regw", 32'(RegWrite), 32'd0);
        tick(6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0);
        chk("addu_exe_state", 32'(state), 32'd2);
        chk("addu_exe_alu", {ALUOp, ALUctrl, RegWrite}, 32'b000_00_0);
        tick(6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0);
        chk("addu_wb_state", 32'(state), 32'd4);
        chk("addu_wb_ctl", {RegWrite, Regdst, WDctrl, instr_done}, 32'b1_10_00_1);

        // lw, ack in third MEM cycle
        nreq = 0;
        tick(6'b100011, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("addu_retired", retired, 32'd1);
        chk("lw_fetch_state", 32'(state), 32'd0);
        tick(6'b100011, 6'd0, 1'b0, 1'b0, 1'b0);
        tick(6'b100011, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("lw_exe_alu", {ALUOp, ALUctrl}, 32'b000_01);
        tick(6'b100011, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("lw_mem1", {3'(state), mem_req, MemWrite}, 32'b011_1_0);
        tick(6'b100011, 6'd0, 1'b0, 1'b0, 1'b0);
        tick(6'b100011, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("lw_mem3", {3'(state), mem_req, instr_done, ALUctrl}, 32'b011_1_0_01);
        tick(6'b100011, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("lw_wb", {3'(state), RegWrite, Regdst, WDctrl, instr_done, mem_req}, 32'b100_1_00_01_1_0);
        chk("lw_nreq", nreq, 32'd3);

        // sw, immediate ack
        nreq = 0;
        tick(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("lw_retired", retired, 32'd2);
        tick(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
        tick(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
        tick(6'b101011, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("sw_mem", {3'(state), mem_req, MemWrite, instr_done}, 32'b011_1_1_1);
        tick(6'b000100, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("sw_next", {3'(state), MemWrite}, 32'b000_0);
        chk("sw_retired", retired, 32'd3);
        chk("sw_nreq", nreq, 32'd1);

        // beq taken then not taken
        tick(6'b000100, 6'd0, 1'b1, 1'b0, 1'b0);
        tick(6'b000100, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("beq_t_exe", {3'(state), PCWrite, PCctrl, instr_done, ALUOp}, 32'b010_1_10_1_001);
        tick(6'b000100, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("beq_t_next", 32'(state), 32'd0);
        chk("beq_t_retired", retired, 32'd4);
        tick(6'b000100, 6'd0, 1'b0, 1'b0, 1'b0);
        tick(6'b000100, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("beq_nt_exe", {3'(state), PCWrite, instr_done}, 32'b010_0_1);

        // jal, jr
        tick(6'b000011, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("beq_nt_retired", retired, 32'd5);
        tick(6'b000011, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("jal_dec", {3'(state), PCWrite, PCctrl, RegWrite, Regdst, WDctrl, instr_done},
            32'b001_1_01_1_01_10_1);
        tick(6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0);
        chk("jal_next", 32'(state), 32'd0);
        tick(6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0);
        chk("jr_dec", {PCWrite, PCctrl, RegWrite, instr_done}, 32'b1_11_0_1);

        // lui
        tick(6'b001111, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("jr_retired", retired, 32'd7);
        tick(6'b001111, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("lui_dec_state", 32'(state), 32'd1);
        tick(6'b001111, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("lui_exe_state", 32'(state), 32'd2);
        tick(6'b001111, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("lui_wb", {RegWrite, Regdst, WDctrl}, 32'b1_00_11);

        // lw timeout: ack high outside MEM must be ignored
        tick(6'b100011, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("lui_retired", retired, 32'd8);
        tick(6'b100011, 6'd0, 1'b0, 1'b1, 1'b0);
        tick(6'b100011, 6'd0, 1'b0, 1'b1, 1'b0);
        nreq = 0; nregw = 0; ndone = 0;
        for (int i = 0; i < 16; i++) tick(6'b100011, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("to_last_state", 32'(state), 32'd3);
        chk("to_last_err", 32'(mem_err), 32'd0);
        tick(6'b000000, 6'b111111, 1'b0, 1'b0, 1'b0);
        chk("to_nreq", nreq, 32'd16);
        chk("to_regw", nregw, 32'd0);
        chk("to_done", ndone, 32'd0);
        chk("to_state", 32'(state), 32'd0);
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_retired", retired, 32'd8);

        // reset in the second MEM cycle of sw
        tick(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
        tick(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
        tick(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
        tick(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("rsw_mem1", {3'(state), mem_req, MemWrite}, 32'b011_1_1);
        tick(6'b101011, 6'd0, 1'b0, 1'b0, 1'b1);
        chk("rsw_mem2", {3'(state), mem_req, MemWrite}, 32'b011_0_0);
        tick(6'b111111, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("rsw_after", {3'(state), mem_err}, 32'b000_0);
        chk("rsw_retired", retired, 32'd0);

        // unknown opcode acts as nop
        tick(6'b111111, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("nop_dec", {3'(state), instr_done, PCWrite, RegWrite, mem_req}, 32'b001_1_0_0_0);
        tick(6'b000000, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("nop_next", 32'(state), 32'd0);
        chk("nop_retired", retired, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
